branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
Parametrised successor to the single-cycle branch resolver. Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters and a tagged branch target buffer (BTB) that predict at fetch. Resolves branch, JAL, JALR and halt in execute, and raises redirect/flush on misprediction. Replaces the combinational halt hack with a RUN/HALT state machine and keeps saturating performance counters.

Parameters:
PC_W, 9, program-counter width in bits; legal range IDX_W+3..32
IDX_W, 4, log2 of table entries (default 16)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
IF_PC  in  PC_W  fetch-stage PC
Pred_Taken  out  1  fetch prediction: taken
Pred_Target  out  PC_W  fetch predicted target; equals IF_PC+4 when not taken
Ex_Valid  in  1  execute-stage instruction valid
Cur_PC  in  PC_W  execute-stage PC
Imm  in  32  sign-extended immediate
Branch  in  1  conditional branch
Jump  in  1  JAL or JALR
Jalr  in  1  JALR (qualifies Jump)
Halt_com  in  1  halt instruction in execute
AluResult  in  32  bit0 = branch condition; full value = JALR target
Ex_PredTaken  in  1  prediction piped from fetch
Ex_PredTarget  in  PC_W  predicted target piped from fetch
Resume  in  1  leave HALT
PC_Imm  out  PC_W  Jalr ? {AluResult[PC_W-1:1],0} : Cur_PC+Imm[PC_W-1:0]
PC_Four  out  PC_W  Cur_PC+4
BrPC  out  PC_W  redirect target
PcSel  out  1  1 = fetch takes BrPC this cycle
Flush  out  1  squash younger instructions
Halted  out  1  FSM in HALT
Br_Cnt  out  CNT_W  resolved branches and jumps
Mis_Cnt  out  CNT_W  mispredictions

Behaviour:
- Reset: on a clk edge with reset=0, all BHT counters go to 01 (weakly not taken), all BTB valid bits clear, FSM goes to RUN and both counters clear. Reset overrides Resume and Halt_com; reset taken while in HALT returns the FSM to RUN.
- Indexing: idx=PC[IDX_W+1:2]; tag=PC[PC_W-1:IDX_W+2]. All PC arithmetic is modulo 2^PC_W, so it wraps.
- Prediction is combinational with zero latency and uses current table contents. Pred_Taken = BTB valid && tag match && BHT counter[1]. Pred_Target = Pred_Taken ? BTB target : IF_PC+4.
- Resolution, combinational and qualified by Ex_Valid in RUN:
  - taken = Jump || (Branch && AluResult[0])
  - target = taken ? PC_Imm : PC_Four
  - mis = (taken != Ex_PredTaken) || (taken && target != Ex_PredTarget)
- Outputs in RUN:
  - If Ex_Valid && Halt_com: PcSel=1, Flush=1, BrPC=Cur_PC, and the halt PC is latched. Halt has priority over a coincident branch or jump; no table or counter update happens.
  - Else if Ex_Valid && mis: PcSel=1, Flush=1, BrPC=target.
  - Else PcSel=0, Flush=0, BrPC=PC_Four.
- Table update on the edge for Ex_Valid, RUN, no Halt_com, and (Branch||Jump):
  - Conditional branch: BHT counter saturating +1 if taken, -1 if not (never wraps past 00 or 11).
  - Taken Branch or JAL: BTB[idx] <= {valid=1, tag, target}.
  - JAL: counter forced to 11.
  - JALR: no table update; still resolved and counted.
- Counters: Br_Cnt +1 per update event. Mis_Cnt +1 when mis for the same events. Both saturate at all-ones.
- FSM states:
  - RUN: transitions to HALT on a valid Halt_com.
  - HALT: Halted=1, PcSel=1, BrPC=halt PC, Flush=1, Ex_Valid ignored, no updates. If Resume=1, outputs PcSel=1, BrPC=halt PC+4, Flush=1, and moves to RUN on the next edge.
- A branch in execute and a fetch of the same index in the same cycle: fetch sees the old entry; there is no bypass.

Decomposition:
- Package branch_pkg:
  - halt_state_t enum {RUN, HALT}
  - counter constants SNT=00, WNT=01, WT=10, ST=11
  - function sat2_update(ctr, taken)
- Sub-module branch_target_table (parameters PC_W, IDX_W) holds the BHT and BTB arrays. It has one combinational read port (IF_PC), one write port and a synchronous active-low clear.
- FSM, resolution and counters live in the top.

Test Plan:
- Reset, then IF_PC=0x010 -> Pred_Taken=0, Pred_Target=0x014; Halted=0; Br_Cnt=0.
- Branch at Cur_PC=0x020, Imm=0x10, AluResult[0]=1, Ex_PredTaken=0 -> PcSel=1, Flush=1, BrPC=0x030, Mis_Cnt=1. Then IF_PC=0x020 -> Pred_Taken=1, Pred_Target=0x030.
- Same branch not taken 3 times -> counter saturates at 00. A 4th not-taken -> no wrap, Pred_Taken=0, and with correct prediction Mis_Cnt unchanged.
- JALR at Cur_PC=0x040, AluResult=0x0A5, Ex_PredTaken=0 -> BrPC=0x0A4, PcSel=1. BTB entry for 0x040 stays invalid.
- Halt_com at Cur_PC=0x050 together with Jump=1 -> BrPC=0x050, no BTB write. Next cycles Halted=1, BrPC=0x050. Resume=1 -> BrPC=0x054, then Halted=0.
- Edge cases:
  - reset=0 during HALT -> next cycle Halted=0 and the tables are cleared.
  - Cur_PC=0x1FC with no branch (PC_W=9) -> PC_Four=0x000.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch predict unit: FSM states and
// 2-bit saturating counter encodings.
package branch_pkg;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} halt_state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'b01;
    else       return (ctr == SNT) ? SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side signal bundle of the branch predict unit; the unit
// itself uses the slave modport, the pipeline drives through master.
interface branch_predict_unit_if #(parameter int PC_W = 9, parameter int CNT_W = 16);

  logic [PC_W-1:0]  IF_PC;
  logic             Pred_Taken;
  logic [PC_W-1:0]  Pred_Target;
  logic             Ex_Valid;
  logic [PC_W-1:0]  Cur_PC;
  logic [31:0]      Imm;
  logic             Branch;
  logic             Jump;
  logic             Jalr;
  logic             Halt_com;
  logic [31:0]      AluResult;
  logic             Ex_PredTaken;
  logic [PC_W-1:0]  Ex_PredTarget;
  logic             Resume;
  logic [PC_W-1:0]  PC_Imm;
  logic [PC_W-1:0]  PC_Four;
  logic [PC_W-1:0]  BrPC;
  logic             PcSel;
  logic             Flush;
  logic             Halted;
  logic [CNT_W-1:0] Br_Cnt;
  logic [CNT_W-1:0] Mis_Cnt;

  modport master (
    output IF_PC, Ex_Valid, Cur_PC, Imm, Branch, Jump, Jalr, Halt_com,
           AluResult, Ex_PredTaken, Ex_PredTarget, Resume,
    input  Pred_Taken, Pred_Target, PC_Imm, PC_Four, BrPC, PcSel, Flush,
           Halted, Br_Cnt, Mis_Cnt
  );

  modport slave (
    input  IF_PC, Ex_Valid, Cur_PC, Imm, Branch, Jump, Jalr, Halt_com,
           AluResult, Ex_PredTaken, Ex_PredTarget, Resume,
    output Pred_Taken, Pred_Target, PC_Imm, PC_Four, BrPC, PcSel, Flush,
           Halted, Br_Cnt, Mis_Cnt
  );

endinterface

// File: rtl/branch_predict_unit_btt.sv
// Direct-mapped BHT (2-bit counters) plus tagged BTB: one combinational
// fetch read port, one execute write port, synchronous active-low clear.
module branch_target_table
  import branch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_taken,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_cond,
  input  logic            wr_jal,
  input  logic            wr_taken,
  input  logic [PC_W-1:0] wr_target
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [1:0]       bht        [N];
  logic             btb_valid  [N];
  logic [TAG_W-1:0] btb_tag    [N];
  logic [PC_W-1:0]  btb_target [N];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             unused_wr_low;

  assign rd_idx        = rd_pc[IDX_W+1:2];
  assign rd_tag        = rd_pc[PC_W-1:IDX_W+2];
  assign wr_idx        = wr_pc[IDX_W+1:2];
  assign wr_tag        = wr_pc[PC_W-1:IDX_W+2];
  assign unused_wr_low = ^wr_pc[1:0];

  // Reads see the table as it stood before this cycle's write.
  assign rd_taken  = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag) && bht[rd_idx][1];
  assign rd_target = rd_taken ? btb_target[rd_idx] : rd_pc + PC_W'(4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        bht[i]       <= WNT;
        btb_valid[i] <= 1'b0;
      end
    end else if (wr_en) begin
      if (wr_jal)
        bht[wr_idx] <= ST;
      else if (wr_cond)
        bht[wr_idx] <= sat2_update(bht[wr_idx], wr_taken);
      if (wr_taken) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= wr_target;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: fetch-time prediction, execute-time resolution with
// redirect/flush, RUN/HALT state machine and saturating perf counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  branch_predict_unit_if.slave bus
);

  halt_state_t      state, state_next;
  logic [PC_W-1:0]  halt_pc;
  logic [PC_W-1:0]  pc_four, pc_imm, target;
  logic             taken, mis, upd, halt_take;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  assign pc_four = bus.Cur_PC + PC_W'(4);
  assign pc_imm  = bus.Jalr ? {bus.AluResult[PC_W-1:1], 1'b0}
                            : bus.Cur_PC + bus.Imm[PC_W-1:0];
  assign taken   = bus.Jump || (bus.Branch && bus.AluResult[0]);
  assign target  = taken ? pc_imm : pc_four;
  assign mis     = (taken != bus.Ex_PredTaken) || (taken && (target != bus.Ex_PredTarget));

  assign halt_take = (state == RUN) && bus.Ex_Valid && bus.Halt_com;
  assign upd       = (state == RUN) && bus.Ex_Valid && !bus.Halt_com && (bus.Branch || bus.Jump);

  assign bus.PC_Four = pc_four;
  assign bus.PC_Imm  = pc_imm;
  assign bus.Br_Cnt  = br_cnt;
  assign bus.Mis_Cnt = mis_cnt;

  if (PC_W < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{bus.AluResult[31:PC_W], bus.Imm[31:PC_W]};
  end

  branch_target_table #(.PC_W(PC_W), .IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (bus.IF_PC),
    .rd_taken  (bus.Pred_Taken),
    .rd_target (bus.Pred_Target),
    .wr_en     (upd && !(bus.Jump && bus.Jalr)),
    .wr_pc     (bus.Cur_PC),
    .wr_cond   (bus.Branch),
    .wr_jal    (bus.Jump && !bus.Jalr),
    .wr_taken  (taken),
    .wr_target (target)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      halt_pc <= '0;
    end else begin
      state <= state_next;
      if (halt_take) halt_pc <= bus.Cur_PC;
    end
  end

  always_comb begin
    state_next = state;
    bus.PcSel  = 1'b0;
    bus.Flush  = 1'b0;
    bus.BrPC   = pc_four;
    bus.Halted = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.Ex_Valid && bus.Halt_com) begin
          bus.PcSel  = 1'b1;
          bus.Flush  = 1'b1;
          bus.BrPC   = bus.Cur_PC;
          state_next = HALT;
        end else if (bus.Ex_Valid && mis) begin
          bus.PcSel = 1'b1;
          bus.Flush = 1'b1;
          bus.BrPC  = target;
        end
      end
      HALT: begin
        bus.Halted = 1'b1;
        bus.PcSel  = 1'b1;
        bus.Flush  = 1'b1;
        bus.BrPC   = halt_pc;
        // Resume steers fetch past the halt instruction while leaving.
        if (bus.Resume) begin
          bus.BrPC   = halt_pc + PC_W'(4);
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (upd) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (mis && (mis_cnt != '1)) mis_cnt <= mis_cnt + 1'b1;
    end
  end

endmodule
